// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants, state encoding and field helpers for the CP0 exception sequencer
//   CP0 register indices, Status/Cause field positions, ExcCode values,
//   sequencer state enum, and word builders for Status and Cause.
package cp0_pkg;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_BD     = 31;

    localparam logic [4:0] EXC_INT = 5'd0;

    typedef enum logic [1:0] {IDLE, EXC_W1, EXC_W2, ERET_W} cp0_state_e;

    function automatic logic [31:0] status_word(input logic [7:0] im, input logic exl, input logic ie);
        status_word = (32'(im) << ST_IM_LO) | (32'(exl) << ST_EXL) | (32'(ie) << ST_IE);
    endfunction

    function automatic logic [31:0] cause_word(input logic bd, input logic [7:0] ip, input logic [4:0] code);
        cause_word = (32'(bd) << CA_BD) | (32'(ip) << CA_IP_LO) | (32'(code) << CA_EXC_LO);
    endfunction
endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: commit/MTC0/interrupt inputs and CP0 write-port/pipeline-control outputs
//   slave  : sequencer view (commit_*, exc_*, eret, mtc0_*, hw_int in; cp0_*, flush, redirect*, busy, exl out)
//   master : pipeline / CP0 file view (directions reversed)
interface cp0_exc_ctrl_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_bd;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [5:0]  hw_int;
    logic [1:0]  cp0_wr;
    logic [4:0]  cp0_a2;
    logic [4:0]  cp0_a3;
    logic [31:0] cp0_wd1;
    logic [31:0] cp0_wd2;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        exl;

    modport slave (
        input  commit_valid, commit_pc, commit_bd, exc_req, exc_code, eret,
               mtc0_we, mtc0_addr, mtc0_data, hw_int,
        output cp0_wr, cp0_a2, cp0_a3, cp0_wd1, cp0_wd2, flush, redirect, redirect_pc, busy, exl
    );

    modport master (
        output commit_valid, commit_pc, commit_bd, exc_req, exc_code, eret,
               mtc0_we, mtc0_addr, mtc0_data, hw_int,
        input  cp0_wr, cp0_a2, cp0_a3, cp0_wd1, cp0_wd2, flush, redirect, redirect_pc, busy, exl
    );
endinterface

// File: rtl/cp0_int_sync.sv
// cp0_int_sync: SYNC_STAGES-deep synchroniser for the six asynchronous hardware interrupt lines
//   clk, reset_n (async active-low) ; d[5:0] raw lines in ; q[5:0] synchronised lines out
module cp0_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] d,
    output logic [5:0] q
);
    logic [SYNC_STAGES-1:0][5:0] r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r <= '0;
        else r <= {r[SYNC_STAGES-2:0], d};
    end

    assign q = r[SYNC_STAGES-1];
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/interrupt/ERET sequencer driving the two CP0 register-file write ports
//   clk, reset_n (async active-low)
//   bus (cp0_exc_ctrl_if.slave):
//     in  commit_valid/commit_pc/commit_bd, exc_req/exc_code, eret, mtc0_we/addr/data, hw_int[5:0]
//     out cp0_wr[1:0] (port1 A2/WD1, port2 A3/WD2), flush, redirect, redirect_pc, busy, exl
//   Optional CP0_TIMER_EN: internal Count/Compare timer whose sticky match flag is ORed into IP[7].
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
    parameter int          SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            reset_n,
    cp0_exc_ctrl_if.slave  bus
);
    cp0_state_e  state;
    logic [7:0]  im;
    logic        ie;
    logic        exl_q;
    logic [31:0] epc;
    logic [1:0]  seq_wr;
    logic [4:0]  seq_a2;
    logic [4:0]  seq_a3;
    logic [31:0] seq_wd1;
    logic [31:0] seq_wd2;
    logic [31:0] redirect_pc_q;
    logic        flush_q;
    logic        redirect_q;
    logic        busy_q;
    logic [5:0]  hw_sync;
    logic [7:0]  ip;
    logic        timer_irq;
    logic        int_pend;
    logic        take_exc;
    logic        accept;
    logic        mtc0_go;
    logic [31:0] epc_n;
    logic [31:0] cause_n;

    cp0_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.hw_int),
        .q       (hw_sync)
    );

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;

    // A Compare write re-arms the timer, so it wins over a coincident match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            compare   <= '0;
            timer_irq <= 1'b0;
        end else begin
            count <= count + 32'd1;
            if (mtc0_go && bus.mtc0_addr == CP0_COMPARE) begin
                compare   <= bus.mtc0_data;
                timer_irq <= 1'b0;
            end else if (count == compare) begin
                timer_irq <= 1'b1;
            end
        end
    end
`else
    assign timer_irq = 1'b0;
`endif

    assign ip       = {hw_sync[5] | timer_irq, hw_sync[4:0], 2'b00};
    assign int_pend = ie & ~exl_q & |(ip & im);
    assign take_exc = int_pend | bus.exc_req;
    assign accept   = state == IDLE && bus.commit_valid && (take_exc || bus.eret);
    // MTC0 belongs to the committing instruction, so any accepted event squashes it.
    assign mtc0_go  = reset_n & (state == IDLE) & ~accept & bus.mtc0_we;
    assign epc_n    = bus.commit_bd ? bus.commit_pc - 32'd4 : bus.commit_pc;
    assign cause_n  = cause_word(bus.commit_bd, ip, int_pend ? EXC_INT : bus.exc_code);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            im            <= '0;
            ie            <= 1'b0;
            exl_q         <= 1'b0;
            epc           <= '0;
            seq_wr        <= '0;
            seq_a2        <= '0;
            seq_a3        <= '0;
            seq_wd1       <= '0;
            seq_wd2       <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            seq_wr        <= '0;
            seq_a2        <= '0;
            seq_a3        <= '0;
            seq_wd1       <= '0;
            seq_wd2       <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            busy_q        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && take_exc) begin
                        state         <= EXC_W1;
                        seq_wr        <= 2'b11;
                        seq_a2        <= CP0_EPC;
                        seq_wd1       <= epc_n;
                        seq_a3        <= CP0_CAUSE;
                        seq_wd2       <= cause_n;
                        flush_q       <= 1'b1;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= EXC_VECTOR;
                        busy_q        <= 1'b1;
                    end else if (accept) begin
                        state         <= ERET_W;
                        seq_wr        <= 2'b01;
                        seq_a3        <= CP0_STATUS;
                        seq_wd2       <= status_word(im, 1'b0, ie);
                        flush_q       <= 1'b1;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= epc;
                        busy_q        <= 1'b1;
                    end else if (mtc0_go) begin
                        if (bus.mtc0_addr == CP0_STATUS) begin
                            im    <= bus.mtc0_data[ST_IM_LO +: 8];
                            exl_q <= bus.mtc0_data[ST_EXL];
                            ie    <= bus.mtc0_data[ST_IE];
                        end
                        if (bus.mtc0_addr == CP0_EPC) epc <= bus.mtc0_data;
                    end
                end
                EXC_W1: begin
                    // seq_wd1 still holds the EPC being written this cycle.
                    epc     <= seq_wd1;
                    state   <= EXC_W2;
                    seq_wr  <= 2'b01;
                    seq_a3  <= CP0_STATUS;
                    seq_wd2 <= status_word(im, 1'b1, ie);
                    busy_q  <= 1'b1;
                end
                EXC_W2: begin
                    exl_q <= 1'b1;
                    state <= IDLE;
                end
                ERET_W: begin
                    exl_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cp0_wr      = mtc0_go ? 2'b10 : seq_wr;
    assign bus.cp0_a2      = mtc0_go ? bus.mtc0_addr : seq_a2;
    assign bus.cp0_wd1     = mtc0_go ? bus.mtc0_data : seq_wd1;
    assign bus.cp0_a3      = seq_a3;
    assign bus.cp0_wd2     = seq_wd2;
    assign bus.flush       = flush_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.busy        = busy_q;
    assign bus.exl         = exl_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed self-checking bench for the CP0 exception sequencer
//   Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cp0_exc_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef CP0_TIMER_EN
    // Tracks the expected value of the internal Count register.
    logic [31:0] cyc;
    always @(posedge clk or negedge reset_n) cyc <= !reset_n ? 32'd0 : cyc + 32'd1;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.commit_valid = 1'b0;
        bus.commit_pc    = '0;
        bus.commit_bd    = 1'b0;
        bus.exc_req      = 1'b0;
        bus.exc_code     = '0;
        bus.eret         = 1'b0;
        bus.mtc0_we      = 1'b0;
        bus.mtc0_addr    = '0;
        bus.mtc0_data    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.hw_int = 6'h3F;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.cp0_a2, bus.cp0_a3, bus.flush, bus.redirect, bus.busy, bus.exl} !== 16'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got wr=%b a2=%0d a3=%0d fl=%b rd=%b busy=%b exl=%b, want all 0",
                     bus.cp0_wr, bus.cp0_a2, bus.cp0_a3, bus.flush, bus.redirect, bus.busy, bus.exl);
        end
        checks++;
        if ({bus.cp0_wd1, bus.cp0_wd2, bus.redirect_pc} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got wd1=%h wd2=%h rpc=%h, want 0", bus.cp0_wd1, bus.cp0_wd2, bus.redirect_pc);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.cp0_wr, bus.busy} !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_%0d: got wr=%b busy=%b, want 00/0", i, bus.cp0_wr, bus.busy);
            end
        end
        bus.hw_int = '0;
        repeat (3) step();
    endtask

    task automatic test_exc(input logic [31:0] pc, input logic bd, input logic [31:0] exp_epc,
                            input logic [31:0] exp_cause, input string nm);
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        bus.commit_bd    = bd;
        bus.exc_req      = 1'b1;
        bus.exc_code     = 5'h0C;
        bus.mtc0_we      = 1'b1;
        bus.mtc0_addr    = 5'd12;
        bus.mtc0_data    = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.busy, bus.flush} !== 4'b0) begin
            errors++;
            $display("FAIL %s_accept: got wr=%b busy=%b flush=%b, want 00/0/0", nm, bus.cp0_wr, bus.busy, bus.flush);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.cp0_a2, bus.cp0_a3, bus.flush, bus.redirect, bus.busy} !== {2'b11, 5'd14, 5'd13, 3'b111}) begin
            errors++;
            $display("FAIL %s_w1_ctrl: got wr=%b a2=%0d a3=%0d fl=%b rd=%b busy=%b, want 11/14/13/1/1/1",
                     nm, bus.cp0_wr, bus.cp0_a2, bus.cp0_a3, bus.flush, bus.redirect, bus.busy);
        end
        checks++;
        if (bus.cp0_wd1 !== exp_epc) begin
            errors++;
            $display("FAIL %s_w1_epc: got %h want %h", nm, bus.cp0_wd1, exp_epc);
        end
        checks++;
        if (bus.cp0_wd2 !== exp_cause) begin
            errors++;
            $display("FAIL %s_w1_cause: got %h want %h", nm, bus.cp0_wd2, exp_cause);
        end
        checks++;
        if (bus.redirect_pc !== 32'h0000_4180) begin
            errors++;
            $display("FAIL %s_w1_rpc: got %h want 00004180", nm, bus.redirect_pc);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.cp0_a3, bus.flush, bus.redirect, bus.busy} !== {2'b01, 5'd12, 3'b001}) begin
            errors++;
            $display("FAIL %s_w2_ctrl: got wr=%b a3=%0d fl=%b rd=%b busy=%b, want 01/12/0/0/1",
                     nm, bus.cp0_wr, bus.cp0_a3, bus.flush, bus.redirect, bus.busy);
        end
        checks++;
        if (bus.cp0_wd2 !== 32'h0000_0002) begin
            errors++;
            $display("FAIL %s_w2_status: got %h want 00000002", nm, bus.cp0_wd2);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.busy, bus.exl} !== 4'b0001) begin
            errors++;
            $display("FAIL %s_done: got wr=%b busy=%b exl=%b, want 00/0/1", nm, bus.cp0_wr, bus.busy, bus.exl);
        end
        step();
    endtask

    task automatic test_eret(input logic [31:0] exp_epc, input logic [31:0] exp_status, input string nm);
        bus.commit_valid = 1'b1;
        bus.commit_pc    = 32'h0000_0800;
        bus.eret         = 1'b1;
        bus.mtc0_we      = 1'b1;
        bus.mtc0_addr    = 5'd14;
        bus.mtc0_data    = 32'hDEAD_BEEC;
        @(negedge clk);
        checks++;
        if (bus.cp0_wr !== 2'b00) begin
            errors++;
            $display("FAIL %s_accept_mtc0: got wr=%b want 00", nm, bus.cp0_wr);
        end
        step();
        idle_inputs();
        bus.mtc0_we   = 1'b1;
        bus.mtc0_addr = 5'd14;
        bus.mtc0_data = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.cp0_a3, bus.flush, bus.redirect, bus.busy} !== {2'b01, 5'd12, 3'b111}) begin
            errors++;
            $display("FAIL %s_ctrl: got wr=%b a3=%0d fl=%b rd=%b busy=%b, want 01/12/1/1/1",
                     nm, bus.cp0_wr, bus.cp0_a3, bus.flush, bus.redirect, bus.busy);
        end
        checks++;
        if (bus.cp0_wd2 !== exp_status) begin
            errors++;
            $display("FAIL %s_status: got %h want %h", nm, bus.cp0_wd2, exp_status);
        end
        checks++;
        if (bus.redirect_pc !== exp_epc) begin
            errors++;
            $display("FAIL %s_rpc: got %h want %h", nm, bus.redirect_pc, exp_epc);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.busy, bus.flush, bus.exl} !== 5'b0) begin
            errors++;
            $display("FAIL %s_done: got wr=%b busy=%b fl=%b exl=%b, want 0", nm, bus.cp0_wr, bus.busy, bus.flush, bus.exl);
        end
        step();
    endtask

    task automatic test_mtc0();
        bus.mtc0_we   = 1'b1;
        bus.mtc0_addr = 5'd14;
        bus.mtc0_data = 32'h0000_2000;
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.cp0_a2, bus.cp0_wd1} !== {2'b10, 5'd14, 32'h0000_2000}) begin
            errors++;
            $display("FAIL mtc0_epc: got wr=%b a2=%0d wd1=%h want 10/14/00002000", bus.cp0_wr, bus.cp0_a2, bus.cp0_wd1);
        end
        step();
        idle_inputs();
        bus.exc_req  = 1'b1;
        bus.exc_code = 5'h0C;
        bus.eret     = 1'b1;
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.busy, bus.flush} !== 4'b0) begin
            errors++;
            $display("FAIL no_commit_ignored: got wr=%b busy=%b fl=%b want 0", bus.cp0_wr, bus.busy, bus.flush);
        end
        step();
    endtask

    task automatic test_interrupt();
        bus.mtc0_we   = 1'b1;
        bus.mtc0_addr = 5'd12;
        bus.mtc0_data = 32'h0000_0401;
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.cp0_a2, bus.cp0_wd1} !== {2'b10, 5'd12, 32'h0000_0401}) begin
            errors++;
            $display("FAIL mtc0_status: got wr=%b a2=%0d wd1=%h want 10/12/00000401", bus.cp0_wr, bus.cp0_a2, bus.cp0_wd1);
        end
        step();
        idle_inputs();
        bus.commit_valid = 1'b1;
        bus.commit_pc    = 32'h0000_5008;
        bus.hw_int       = 6'h01;
        step();
        step();
        bus.exc_req  = 1'b1;
        bus.exc_code = 5'h0C;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL int_sync_latency: got busy=%b want 0", bus.busy);
        end
        step();
        idle_inputs();
        bus.hw_int = '0;
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.flush, bus.redirect, bus.busy, bus.redirect_pc} !== {2'b11, 3'b111, 32'h0000_4180}) begin
            errors++;
            $display("FAIL int_w1_ctrl: got wr=%b fl=%b rd=%b busy=%b rpc=%h want 11/1/1/1/00004180",
                     bus.cp0_wr, bus.flush, bus.redirect, bus.busy, bus.redirect_pc);
        end
        checks++;
        if ({bus.cp0_wd1, bus.cp0_wd2} !== {32'h0000_5008, 32'h0000_0400}) begin
            errors++;
            $display("FAIL int_w1_data: got epc=%h cause=%h want 00005008/00000400", bus.cp0_wd1, bus.cp0_wd2);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.cp0_wr, bus.cp0_wd2} !== {2'b01, 32'h0000_0403}) begin
            errors++;
            $display("FAIL int_w2_status: got wr=%b wd2=%h want 01/00000403", bus.cp0_wr, bus.cp0_wd2);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.exl !== 1'b1) begin
            errors++;
            $display("FAIL int_exl: got %b want 1", bus.exl);
        end
        step();
        bus.hw_int       = 6'h01;
        bus.commit_valid = 1'b1;
        bus.commit_pc    = 32'h0000_5010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.cp0_wr, bus.busy, bus.flush} !== 4'b0) begin
                errors++;
                $display("FAIL int_masked_%0d: got wr=%b busy=%b fl=%b want 0", i, bus.cp0_wr, bus.busy, bus.flush);
            end
            step();
        end
        bus.hw_int = '0;
        idle_inputs();
        repeat (3) step();
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        int n;
        bus.mtc0_we   = 1'b1;
        bus.mtc0_addr = 5'd11;
        bus.mtc0_data = cyc + 32'd20;
        step();
        bus.mtc0_addr = 5'd12;
        bus.mtc0_data = 32'h0000_8001;
        step();
        idle_inputs();
        bus.commit_valid = 1'b1;
        bus.commit_pc    = 32'h0000_6000;
        n = 2;
        @(negedge clk);
        while (bus.redirect !== 1'b1 && n < 40) begin
            step();
            n++;
            @(negedge clk);
        end
        checks++;
        if (n < 21 || n > 23) begin
            errors++;
            $display("FAIL timer_delay: got %0d cycles want 21..23", n);
        end
        checks++;
        if (bus.cp0_wd2 !== 32'h0000_8000) begin
            errors++;
            $display("FAIL timer_cause: got %h want 00008000", bus.cp0_wd2);
        end
        idle_inputs();
        step();
        step();
        bus.mtc0_we   = 1'b1;
        bus.mtc0_addr = 5'd11;
        bus.mtc0_data = cyc + 32'd5000;
        step();
        idle_inputs();
        test_eret(32'h0000_6000, 32'h0000_8001, "timer_eret");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.hw_int = '0;
        idle_inputs();
        test_reset();
        test_exc(32'h0000_3010, 1'b0, 32'h0000_3010, 32'h0000_0030, "exc_nobd");
        test_exc(32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h8000_0030, "exc_bd");
        test_eret(32'hFFFF_FFFC, 32'h0000_0000, "eret1");
        test_mtc0();
        test_eret(32'h0000_2000, 32'h0000_0000, "eret2");
        test_interrupt();
        test_eret(32'h0000_5008, 32'h0000_0401, "eret3");
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
